// File: rtl/temp_adc_pkg.sv
// Shared types and constants for the temperature ADC reader
// and the downstream over-temperature monitors.
package temp_adc_pkg;

   localparam int ADC_W = 12;
   localparam int CFG_W = 6;

   // 40C in raw ADC counts; shared with the over-temp compare logic
   localparam logic [ADC_W-1:0] TEMP_40C = 12'd3643;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      SHIFT,
      LATCH
   } adc_state_t;

   // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep
   function automatic logic [CFG_W-1:0] cfg_word(
      input logic [2:0] ch
   );
      return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
   endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI bit engine: SCLK divider, bit counter and the
// config/result shift registers for one 12-bit frame.
module adc_spi_shifter
   import temp_adc_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CFG_W-1:0] cfg,
   input  logic             sdo,
   output logic             sck,
   output logic             sdi,
   output logic             done,
   output logic [ADC_W-1:0] data
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic             active;
   logic [DW-1:0]    div_cnt;
   logic [3:0]       bit_cnt;
   logic [CFG_W-1:0] cfg_sr;
   logic             tick;

   assign tick = active && (div_cnt == DW'(CLK_DIV - 1));

   // high during the last clk of the final SCLK high half
   assign done = tick && sck && (bit_cnt == 4'(ADC_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         cfg_sr  <= '0;
         sck     <= 1'b0;
         sdi     <= 1'b0;
         data    <= '0;
      end else if (start) begin
         active  <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         sck     <= 1'b0;
         sdi     <= cfg[CFG_W-1];
         cfg_sr  <= {cfg[CFG_W-2:0], 1'b0};
      end else if (active) begin
         if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
            if (!sck) begin
               data <= {data[ADC_W-2:0], sdo};
            end else begin
               // zeros shift in behind the config bits
               sdi     <= cfg_sr[CFG_W-1];
               cfg_sr  <= {cfg_sr[CFG_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
               if (done) begin
                  active <= 1'b0;
               end
            end
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/temp_adc_reader.sv
// Periodic LTC2308-style SPI reader producing temp[11:0]
// with a one-cycle temp_valid strobe.
module temp_adc_reader
   import temp_adc_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int CONV_CYCLES   = 80,
   parameter int SAMPLE_PERIOD = 50000,
   parameter int ADC_CH        = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             adc_convst,
   output logic             adc_sck,
   output logic             adc_sdi,
   input  logic             adc_sdo,
   output logic [ADC_W-1:0] temp,
   output logic             temp_valid,
   output logic             busy
);

   localparam int PW = $clog2(SAMPLE_PERIOD + 1);
   localparam int CW = $clog2(CONV_CYCLES + 1);
   localparam logic [CFG_W-1:0] CFG =
      cfg_word(3'(ADC_CH));

   adc_state_t       state;
   adc_state_t       next_state;
   logic [PW-1:0]    period_cnt;
   logic [CW-1:0]    conv_cnt;
   logic             en_d;
   logic             en_rise;
   logic             first_frame;
   logic             spi_start;
   logic             spi_done;
   logic [ADC_W-1:0] spi_data;

   assign en_rise = en && !en_d;

   adc_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .start (spi_start),
      .cfg   (CFG),
      .sdo   (adc_sdo),
      .sck   (adc_sck),
      .sdi   (adc_sdi),
      .done  (spi_done),
      .data  (spi_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (en && (period_cnt == '0
                       || first_frame || en_rise)) begin
               next_state = CONV;
            end
         end
         CONV: begin
            if (conv_cnt == '0) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (spi_done) begin
               next_state = LATCH;
            end
         end
         LATCH: next_state = IDLE;
      endcase
   end

   always_comb begin
      adc_convst = (state == CONV);
      busy       = (state != IDLE);
      spi_start  = (state == CONV) && (conv_cnt == '0);
   end

   // period counter runs frame-to-frame, parks at 0 when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
         conv_cnt   <= '0;
      end else if (state == IDLE && next_state == CONV) begin
         period_cnt <= PW'(SAMPLE_PERIOD - 1);
         conv_cnt   <= CW'(CONV_CYCLES - 1);
      end else begin
         if (period_cnt != '0) begin
            period_cnt <= period_cnt - PW'(1);
         end
         if (conv_cnt != '0) begin
            conv_cnt <= conv_cnt - CW'(1);
         end
      end
   end

   // the first frame only programs the channel; its data is stale
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d        <= 1'b0;
         first_frame <= 1'b1;
         temp        <= '0;
         temp_valid  <= 1'b0;
      end else begin
         en_d       <= en;
         temp_valid <= 1'b0;
         if (state == LATCH && !first_frame) begin
            temp       <= spi_data;
            temp_valid <= 1'b1;
         end
         if (en_rise) begin
            first_frame <= 1'b1;
         end else if (state == LATCH) begin
            first_frame <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_temp_adc_reader.sv
// Randomized bench for temp_adc_reader: two instances
// (ch0/period 200, ch5/period 20) against a cycle-level model.
module tb_temp_adc_reader;

   localparam int CDIV  = 2;
   localparam int CONVC = 4;
   localparam int SP_A  = 200;
   localparam int SP_B  = 20;
   localparam int FRAME = CONVC + 24 * CDIV + 1;

   logic        clk;
   logic        rst_n;
   logic        en     [2];
   logic        convst [2];
   logic        sck    [2];
   logic        sdi    [2];
   logic        sdo    [2];
   logic        valid  [2];
   logic        busy   [2];
   logic [11:0] temp   [2];

   int          n_chk;
   int          n_err;
   int          cyc;
   int          nfr;
   logic [11:0] dir_w  [6];

   logic        in_fr     [2];
   logic        fv        [2];
   logic        primed    [2];
   logic        cv_p      [2];
   logic        sck_p     [2];
   logic        en_p      [2];
   logic [11:0] fw        [2];
   logic [11:0] sr        [2];
   logic [11:0] bits      [2];
   logic [11:0] exp_temp  [2];
   int          conv_t    [2];
   int          last_rise [2];
   int          pulses    [2];
   int          vcnt      [2];
   int          rises     [2];

   temp_adc_reader #(
      .CLK_DIV       (CDIV),
      .CONV_CYCLES   (CONVC),
      .SAMPLE_PERIOD (SP_A),
      .ADC_CH        (0)
   ) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[0]),
      .adc_convst (convst[0]),
      .adc_sck    (sck[0]),
      .adc_sdi    (sdi[0]),
      .adc_sdo    (sdo[0]),
      .temp       (temp[0]),
      .temp_valid (valid[0]),
      .busy       (busy[0])
   );

   temp_adc_reader #(
      .CLK_DIV       (CDIV),
      .CONV_CYCLES   (CONVC),
      .SAMPLE_PERIOD (SP_B),
      .ADC_CH        (5)
   ) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[1]),
      .adc_convst (convst[1]),
      .adc_sck    (sck[1]),
      .adc_sdi    (sdi[1]),
      .adc_sdo    (sdo[1]),
      .temp       (temp[1]),
      .temp_valid (valid[1]),
      .busy       (busy[1])
   );

   assign sdo[0] = sr[0][11];
   assign sdo[1] = sr[1][11];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h @cyc %0d",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic int exp_period(input int sp);
      return (sp > FRAME + 1) ? sp : FRAME + 1;
   endfunction

   function automatic logic [5:0] exp_cfg(input int i);
      return (i == 0) ? 6'b100010 : 6'b111010;
   endfunction

   // ADC model plus reference model, evaluated mid-cycle
   always @(negedge clk) begin
      logic rise;
      logic srise;
      logic sfall;
      logic eb;
      logic ec;
      logic ev;
      int   d;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            in_fr[i]     = 1'b0;
            primed[i]    = 1'b0;
            exp_temp[i]  = '0;
            last_rise[i] = -1;
            sck_p[i]     = 1'b0;
            cv_p[i]      = 1'b0;
            en_p[i]      = en[i];
         end else begin
            if (en[i] != en_p[i]) begin
               last_rise[i] = -1;
               if (en[i]) primed[i] = 1'b0;
            end
            en_p[i] = en[i];
            rise  = convst[i] && !cv_p[i];
            srise = sck[i] && !sck_p[i];
            sfall = !sck[i] && sck_p[i];
            if (rise) begin
               if (last_rise[i] >= 0) begin
                  chk($sformatf("period%0d", i),
                      32'(cyc - last_rise[i]),
                      32'(exp_period(i == 0 ? SP_A : SP_B)));
               end
               last_rise[i] = cyc;
               conv_t[i]    = cyc;
               in_fr[i]     = 1'b1;
               fv[i]        = primed[i];
               if (i == 0 && nfr < 6) fw[i] = dir_w[nfr];
               else fw[i] = 12'($urandom);
               if (i == 0) nfr++;
               sr[i]     = fw[i];
               pulses[i] = 0;
               bits[i]   = '0;
               rises[i]++;
            end
            if (srise) begin
               pulses[i]++;
               bits[i] = {bits[i][10:0], sdi[i]};
            end
            if (sfall) sr[i] = {sr[i][10:0], 1'b0};
            d  = in_fr[i] ? cyc - conv_t[i] : -1;
            eb = in_fr[i] && d <= FRAME - 1;
            ec = in_fr[i] && d < CONVC;
            ev = in_fr[i] && d == FRAME && fv[i];
            if (in_fr[i] && d == FRAME - 1) begin
               chk($sformatf("sck_n%0d", i),
                   32'(pulses[i]), 32'd12);
               chk($sformatf("cfg%0d", i), 32'(bits[i]),
                   32'({exp_cfg(i), 6'b0}));
            end
            if (ev) exp_temp[i] = fw[i];
            if (in_fr[i] && d == FRAME) begin
               primed[i] = 1'b1;
               in_fr[i]  = 1'b0;
            end
            chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(eb));
            chk($sformatf("convst%0d", i),
                32'(convst[i]), 32'(ec));
            chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(ev));
            chk($sformatf("temp%0d", i),
                32'(temp[i]), 32'(exp_temp[i]));
            if (valid[i]) vcnt[i]++;
            cv_p[i]  = convst[i];
            sck_p[i] = sck[i];
         end
      end
   end

   task automatic wait_valid(input int i, input int n,
                             input int budget);
      int k = 0;
      while (vcnt[i] < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (vcnt[i] < n)
         chk($sformatf("wait_v%0d", i), 32'(vcnt[i]), 32'(n));
   endtask

   task automatic chk_zero(input string t, input int i);
      chk({t, "_convst"}, 32'(convst[i]), 32'd0);
      chk({t, "_sck"},    32'(sck[i]),    32'd0);
      chk({t, "_sdi"},    32'(sdi[i]),    32'd0);
      chk({t, "_temp"},   32'(temp[i]),   32'd0);
      chk({t, "_valid"},  32'(valid[i]),  32'd0);
      chk({t, "_busy"},   32'(busy[i]),   32'd0);
   endtask

   initial begin
      int v;
      int r;
      int k;
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      nfr   = 0;
      for (int i = 0; i < 2; i++) begin
         vcnt[i]  = 0;
         rises[i] = 0;
      end
      dir_w[0] = 12'hE3B;
      dir_w[1] = 12'hE3B;
      dir_w[2] = 12'h000;
      dir_w[3] = 12'hFFF;
      dir_w[4] = 12'hE3A;
      dir_w[5] = 12'hE3B;
      en[0] = 1'b0;
      en[1] = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("rst_a", 0);
      chk_zero("rst_b", 1);
      rst_n = 1'b1;
      en[0] = 1'b1;
      en[1] = 1'b1;

      // first frame silent, then the directed words in order
      for (int n = 1; n < 6; n++) begin
         wait_valid(0, n, 400);
         chk($sformatf("word%0d", n), 32'(temp[0]),
             32'(dir_w[n]));
      end
      chk("t1_frames", 32'(rises[0]), 32'd6);
      wait_valid(0, 9, 1200);

      // drop en mid-SHIFT
      k = 0;
      while (!(in_fr[0] && pulses[0] == 3) && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t4_inshift", 32'(pulses[0]), 32'd3);
      v = vcnt[0];
      r = rises[0];
      en[0] = 1'b0;
      wait_valid(0, v + 1, 100);
      repeat (400) @(posedge clk);
      #1;
      chk("t4_idle", 32'(rises[0]), 32'(r));
      chk("t4_convst", 32'(convst[0]), 32'd0);
      chk("t4_vcnt", 32'(vcnt[0]), 32'(v + 1));
      en[0] = 1'b1;
      v = vcnt[0];
      wait_valid(0, v + 1, 600);
      chk("t4_disc", 32'(rises[0]), 32'(r + 2));

      // reset during SCLK 6
      k = 0;
      while (!(in_fr[0] && pulses[0] == 6 && sck[0])
             && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t5_sclk6", 32'(sck[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("t5", 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      r = rises[0];
      v = vcnt[0];
      k = 0;
      while (rises[0] < r + 1 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t5_start", 32'(rises[0]), 32'(r + 1));
      repeat (FRAME + 5) @(posedge clk);
      #1;
      chk("t5_nospur", 32'(vcnt[0]), 32'(v));
      wait_valid(0, v + 1, 600);
      chk("t5_recov", 32'(rises[0]), 32'(r + 2));
      chk("b_run", 32'(rises[1] > 10), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
